multicycle_ctrl_fsm: RTL and testbench

//  RISC-V RV32I multicycle main controller with a memory ready handshake, wait timeout and retired-instruction counter.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_fsm_if.sv | 36 +++
 rtl/multicycle_ctrl_fsm_mem_wait_timer.sv | 24 ++
 rtl/multicycle_ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the RV32I multicycle controller.
// Optional feature macro used by the controller: ILLEGAL_TRAP_EN.
package multicycle_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECR    = 4'd7,
      EXECI    = 4'd8,
      ALUWB    = 4'd9,
      JAL      = 4'd10,
      BEQ      = 4'd11,
      ERR      = 4'd12,
      TRAP     = 4'd13
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Datapath control word decoded from the current state.
   typedef struct packed {
      logic       adr_src;
      logic       ir_write;
      logic       pc_update;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       mem_req;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller side.
interface multicycle_ctrl_fsm_if #(parameter int RET_CNT_W = 32);
   logic                 start;
   logic [6:0]           opcode;
   logic                 mem_ready;
   logic [3:0]           state;
   logic                 adr_src;
   logic                 ir_write;
   logic                 pc_update;
   logic                 reg_write;
   logic                 mem_write;
   logic                 branch;
   logic [1:0]           alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           alu_op;
   logic [1:0]           result_src;
   logic                 mem_req;
   logic                 busy;
   logic [RET_CNT_W-1:0] instr_count;
   logic                 timeout_err;
   logic                 illegal_op;

   modport master (
      input  start, opcode, mem_ready,
      output state, adr_src, ir_write, pc_update, reg_write, mem_write, branch,
             alu_src_a, alu_src_b, alu_op, result_src, mem_req, busy,
             instr_count, timeout_err, illegal_op
   );

   modport slave (
      output start, opcode, mem_ready,
      input  state, adr_src, ir_write, pc_update, reg_write, mem_write, branch,
             alu_src_a, alu_src_b, alu_op, result_src, mem_req, busy,
             instr_count, timeout_err, illegal_op
   );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Per-access memory wait counter. Counts consecutive not-ready cycles of one
// access and pulses timeout on the MAX_WAIT-th one (a ready in that cycle wins).
module mem_wait_timer #(
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic ready,
   output logic timeout
);
   logic [WAIT_W-1:0] cnt;

   // Count stalled cycles; clear when idle or when the access completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (clear || ready) cnt <= '0;
      else if (en)            cnt <= cnt + WAIT_W'(1);
   end

   assign timeout = en && !ready && (cnt == WAIT_W'(MAX_WAIT - 1));
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// RV32I multicycle main controller: FSM, control decode, retire counter.
// Macro ILLEGAL_TRAP_EN: undefined opcodes trap (sticky illegal_op) instead
// of being silently skipped.
module multicycle_ctrl_fsm
   import multicycle_pkg::*;
#(
   parameter int WAIT_W    = 4,
   parameter int MAX_WAIT  = 15,
   parameter int RET_CNT_W = 32
) (
   input logic                 clk,
   input logic                 rst,
   multicycle_ctrl_fsm_if.master bus
);
   state_e               state_q, state_d;
   ctrl_t                ctrl;
   logic                 timeout;
   logic                 retire;
   logic [RET_CNT_W-1:0] count_q;
   logic                 timeout_q;
   logic                 illegal_q;

   mem_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!ctrl.mem_req),
      .en      (ctrl.mem_req),
      .ready   (bus.mem_ready),
      .timeout (timeout)
   );

   // Next-state logic; memory states hold until ready or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (bus.start) state_d = FETCH;
         FETCH:    if (bus.mem_ready) state_d = DECODE;
                   else if (timeout) state_d = ERR;
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECR;
               OP_I:         state_d = EXECI;
               OP_JAL:       state_d = JAL;
               OP_BEQ:       state_d = BEQ;
`ifdef ILLEGAL_TRAP_EN
               default:      state_d = TRAP;
`else
               default:      state_d = FETCH;
`endif
            endcase
         end
         MEMADR:   state_d = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
                   else if (timeout) state_d = ERR;
         MEMWB:    state_d = FETCH;
         MEMWRITE: if (bus.mem_ready) state_d = FETCH;
                   else if (timeout) state_d = ERR;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         JAL:      state_d = ALUWB;
         BEQ:      state_d = FETCH;
         ERR:      state_d = ERR;
`ifdef ILLEGAL_TRAP_EN
         TRAP:     state_d = TRAP;
`endif
         default:  state_d = IDLE;
      endcase
   end

   // Moore control decode; FETCH gates its IR/PC writes on the ready cycle.
   always_comb begin
      ctrl = '0;
      case (state_q)
         FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_op     = ALU_ADD;
            ctrl.result_src = RES_ALURESULT;
            ctrl.ir_write   = bus.mem_ready;
            ctrl.pc_update  = bus.mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
         end
         MEMADR: begin
            ctrl.alu_src_a = SRCA_RD1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.adr_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         EXECR: begin
            ctrl.alu_src_a = SRCA_RD1;
            ctrl.alu_src_b = SRCB_RD2;
            ctrl.alu_op    = ALU_FUNCT;
         end
         EXECI: begin
            ctrl.alu_src_a = SRCA_RD1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_FUNCT;
         end
         ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
         end
         JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_update  = 1'b1;
         end
         BEQ: begin
            ctrl.alu_src_a  = SRCA_RD1;
            ctrl.alu_src_b  = SRCB_RD2;
            ctrl.alu_op     = ALU_SUB;
            ctrl.result_src = RES_ALUOUT;
            ctrl.branch     = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // JAL retires through ALUWB, so it is counted exactly once.
   assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                   ((state_q == MEMWRITE) && bus.mem_ready);

   // State register and retire counter (wraps silently).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) count_q <= count_q + RET_CNT_W'(1);
      end
   end

   // Sticky error flags; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (timeout) timeout_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
         if ((state_q == DECODE) && (state_d == TRAP)) illegal_q <= 1'b1;
`endif
      end
   end

   assign bus.state       = state_q;
   assign bus.adr_src     = ctrl.adr_src;
   assign bus.ir_write    = ctrl.ir_write;
   assign bus.pc_update   = ctrl.pc_update;
   assign bus.reg_write   = ctrl.reg_write;
   assign bus.mem_write   = ctrl.mem_write;
   assign bus.branch      = ctrl.branch;
   assign bus.alu_src_a   = ctrl.alu_src_a;
   assign bus.alu_src_b   = ctrl.alu_src_b;
   assign bus.alu_op      = ctrl.alu_op;
   assign bus.result_src  = ctrl.result_src;
   assign bus.mem_req     = ctrl.mem_req;
   assign bus.busy        = !((state_q == IDLE) || (state_q == ERR) || (state_q == TRAP));
   assign bus.instr_count = count_q;
   assign bus.timeout_err = timeout_q;
   assign bus.illegal_op  = illegal_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares. Honors ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl_fsm;
   import multicycle_pkg::*;

   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   multicycle_ctrl_fsm_if #(.RET_CNT_W(CW)) bus ();

   multicycle_ctrl_fsm #(.WAIT_W(4), .MAX_WAIT(15), .RET_CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // enable bits: {ir_write, pc_update, reg_write, mem_write, branch, mem_req}
   localparam logic [5:0] E0    = 6'b000000;
   localparam logic [5:0] E_FIR = 6'b110001;
   localparam logic [5:0] E_MRQ = 6'b000001;
   localparam logic [5:0] E_RW  = 6'b001000;
   localparam logic [5:0] E_PC  = 6'b010000;
   localparam logic [5:0] E_MW  = 6'b000101;
   localparam logic [5:0] E_BR  = 6'b000010;

   typedef struct {
      string          name;
      logic [3:0]     st;
      logic [5:0]     en;
      logic [8:0]     sel;
      logic           busy;
      logic [CW-1:0]  cnt;
      logic           te;
      logic           il;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic exp_te  = 1'b0;
   logic exp_il  = 1'b0;

   // Select table {adr_src, alu_src_a, alu_src_b, alu_op, result_src} by state.
   function automatic logic [8:0] sel_of(input logic [3:0] st);
      case (st)
         4'd1:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10}; // FETCH
         4'd2:    return {1'b0, 2'b01, 2'b01, 2'b00, 2'b00}; // DECODE
         4'd3:    return {1'b0, 2'b10, 2'b01, 2'b00, 2'b00}; // MEMADR
         4'd4:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00}; // MEMREAD
         4'd5:    return {1'b0, 2'b00, 2'b00, 2'b00, 2'b01}; // MEMWB
         4'd6:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00}; // MEMWRITE
         4'd7:    return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00}; // EXECR
         4'd8:    return {1'b0, 2'b10, 2'b01, 2'b10, 2'b00}; // EXECI
         4'd10:   return {1'b0, 2'b01, 2'b10, 2'b00, 2'b00}; // JAL
         4'd11:   return {1'b0, 2'b10, 2'b00, 2'b01, 2'b00}; // BEQ
         default: return 9'b0;                               // IDLE/ALUWB/ERR/TRAP
      endcase
   endfunction

   task automatic push(input string name, input logic [3:0] st, input logic [5:0] en, input int cnt);
      exp_t e;
      e.name = name;
      e.st   = st;
      e.en   = en;
      e.sel  = sel_of(st);
      e.busy = !(st == 4'd0 || st == 4'd12 || st == 4'd13);
      e.cnt  = CW'(cnt);
      e.te   = exp_te;
      e.il   = exp_il;
      sb.push_back(e);
   endtask

   // Drive one cycle's inputs and queue what the DUT must show in that cycle.
   task automatic step(input string name, input logic s, input logic rdy, input logic [6:0] op,
                       input logic [3:0] st, input logic [5:0] en, input int cnt);
      bus.start     = s;
      bus.mem_ready = rdy;
      bus.opcode    = op;
      push(name, st, en, cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.mem_ready = 1'b0;
      bus.opcode    = 7'b0;
      exp_te        = 1'b0;
      exp_il        = 1'b0;
      #1;
      push("reset", IDLE, E0, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Assert reset between clock edges and check the outputs clear before any edge.
   task automatic async_rst();
      #1;
      rst    = 1'b1;
      exp_te = 1'b0;
      exp_il = 1'b0;
      #1;
      push("async_rst", IDLE, E0, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: pop one expectation per cycle on the falling edge and compare.
   always @(negedge clk) begin : mon
      exp_t       e;
      logic [5:0] gen;
      logic [8:0] gsel;
      if (sb.size() > 0) begin
         e    = sb.pop_front();
         gen  = {bus.ir_write, bus.pc_update, bus.reg_write, bus.mem_write, bus.branch, bus.mem_req};
         gsel = {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
         n_total++;
         if (bus.state === e.st && gen === e.en && gsel === e.sel && bus.busy === e.busy &&
             bus.instr_count === e.cnt && bus.timeout_err === e.te && bus.illegal_op === e.il)
            n_pass++;
         else
            $display("FAIL %s: got st=%0d en=%b sel=%b busy=%b cnt=%0d te=%b il=%b, expected st=%0d en=%b sel=%b busy=%b cnt=%0d te=%b il=%b",
                     e.name, bus.state, gen, gsel, bus.busy, bus.instr_count, bus.timeout_err, bus.illegal_op,
                     e.st, e.en, e.sel, e.busy, e.cnt, e.te, e.il);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin : stim
      do_reset();

      // R-type, memory always ready
      step("t1_idle",   1, 1, OP_R, IDLE,   E0,    0);
      step("t1_fetch",  0, 1, OP_R, FETCH,  E_FIR, 0);
      step("t1_decode", 0, 1, OP_R, DECODE, E0,    0);
      step("t1_execr",  0, 1, OP_R, EXECR,  E0,    0);
      step("t1_aluwb",  0, 1, OP_R, ALUWB,  E_RW,  0);

      // LW: fetch waits 3 cycles, memread waits 2; start ignored mid-instruction
      repeat (3) step("t2_fetch_wait", 0, 0, OP_LW, FETCH, E_MRQ, 1);
      step("t2_fetch_rdy", 0, 1, OP_LW, FETCH,  E_FIR, 1);
      step("t2_decode",    1, 0, OP_LW, DECODE, E0,    1);
      step("t2_memadr",    0, 0, OP_LW, MEMADR, E0,    1);
      repeat (2) step("t2_memread_wait", 0, 0, OP_LW, MEMREAD, E_MRQ, 1);
      step("t2_memread_rdy", 0, 1, OP_LW, MEMREAD, E_MRQ, 1);
      step("t2_memwb",       0, 0, OP_LW, MEMWB,   E_RW,  1);

      // JAL then BEQ; the BEQ retire wraps the 2-bit counter 3 -> 0
      step("t4_fetch",   0, 1, OP_JAL, FETCH,  E_FIR, 2);
      step("t4_decode",  0, 0, OP_JAL, DECODE, E0,    2);
      step("t4_jal",     0, 0, OP_JAL, JAL,    E_PC,  2);
      step("t4_aluwb",   0, 0, OP_JAL, ALUWB,  E_RW,  2);
      step("t4_fetch2",  0, 1, OP_BEQ, FETCH,  E_FIR, 3);
      step("t4_decode2", 0, 0, OP_BEQ, DECODE, E0,    3);
      step("t4_beq",     0, 0, OP_BEQ, BEQ,    E_BR,  3);

      // undefined opcode
      step("t5_fetch",  0, 1, 7'b0000000, FETCH,  E_FIR, 0);
      step("t5_decode", 0, 0, 7'b0000000, DECODE, E0,    0);
`ifdef ILLEGAL_TRAP_EN
      exp_il = 1'b1;
      step("t5_trap",      1, 1, 7'b0000000, TRAP, E0, 0);
      step("t5_trap_hold", 1, 1, OP_R,       TRAP, E0, 0);
`else
      step("t5_skip",      0, 0, OP_R, FETCH, E_MRQ, 0);
      step("t5_skip_hold", 0, 0, OP_R, FETCH, E_MRQ, 0);
`endif
      do_reset();

      // SW, ready arrives on the 15th MEMWRITE cycle: no timeout
      step("t3b_idle",   1, 0, OP_SW, IDLE,   E0,    0);
      step("t3b_fetch",  0, 1, OP_SW, FETCH,  E_FIR, 0);
      step("t3b_decode", 0, 0, OP_SW, DECODE, E0,    0);
      step("t3b_memadr", 0, 0, OP_SW, MEMADR, E0,    0);
      repeat (14) step("t3b_memwrite_wait", 0, 0, OP_SW, MEMWRITE, E_MW, 0);
      step("t3b_memwrite_rdy15", 0, 1, OP_SW, MEMWRITE, E_MW, 0);

      // reset in the middle of a store
      step("t6_fetch",    0, 1, OP_SW, FETCH,    E_FIR, 1);
      step("t6_decode",   0, 0, OP_SW, DECODE,   E0,    1);
      step("t6_memadr",   0, 0, OP_SW, MEMADR,   E0,    1);
      step("t6_memwrite", 0, 0, OP_SW, MEMWRITE, E_MW,  1);
      async_rst();
      step("t6_after_rst",  0, 1, OP_SW, IDLE, E0, 0);
      step("t6_after_rst2", 0, 1, OP_SW, IDLE, E0, 0);

      // SW, 15 not-ready cycles: timeout to ERR, start and ready then ignored
      step("t3a_idle",   1, 0, OP_SW, IDLE,   E0,    0);
      step("t3a_fetch",  0, 1, OP_SW, FETCH,  E_FIR, 0);
      step("t3a_decode", 0, 0, OP_SW, DECODE, E0,    0);
      step("t3a_memadr", 0, 0, OP_SW, MEMADR, E0,    0);
      repeat (15) step("t3a_memwrite_wait", 0, 0, OP_SW, MEMWRITE, E_MW, 0);
      exp_te = 1'b1;
      step("t3a_err",      1, 1, OP_SW, ERR, E0, 0);
      step("t3a_err_hold", 1, 1, OP_SW, ERR, E0, 0);

      // every queued expectation must have been consumed
      repeat (2) @(negedge clk);
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
